// File: rtl/gray_counter_if.sv
// gray_counter_if: control and status bundle of the Gray counter
interface gray_counter_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_b;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] g;
   logic             tc;
   logic             ovf;

   modport master (
      output en, up, load, load_b,
      input  b, g, tc, ovf
   );

   modport slave (
      input  en, up, load, load_b,
      output b, g, tc, ovf
   );
endinterface

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with a coherent registered Gray image; wraps when GRAY_COUNTER_WRAP_EN is defined, saturates otherwise
module gray_counter #(
   parameter int WIDTH = 3
) (
   input logic          clk,
   input logic          rst,
   gray_counter_if.slave bus
);
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_g;
   logic [WIDTH-1:0] w_b_nxt;
   logic [WIDTH-1:0] w_g_nxt;
   logic             w_tc;
   logic             w_step;

   // terminal count follows the live direction so a reversal is seen immediately
   always_comb w_tc = bus.up ? &r_b : ~|r_b;

   // next binary value by priority load > step > hold; Gray is derived from it so g never lags b
   always_comb begin
`ifdef GRAY_COUNTER_WRAP_EN
      w_step  = bus.en;
`else
      w_step  = bus.en & ~w_tc;
`endif
      w_b_nxt = bus.load ? bus.load_b : w_step ? (bus.up ? r_b + WIDTH'(1) : r_b - WIDTH'(1)) : r_b;
      w_g_nxt = w_b_nxt ^ (w_b_nxt >> 1);
   end

   // binary and Gray registers update on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_b <= '0;
         r_g <= '0;
      end else begin
         r_b <= w_b_nxt;
         r_g <= w_g_nxt;
      end
   end

`ifdef GRAY_COUNTER_WRAP_EN
   logic r_ovf;

   // one-cycle pulse after an enabled, non-load step taken from a terminal value
   always_ff @(posedge clk) begin
      if (rst) r_ovf <= 1'b0;
      else     r_ovf <= bus.en & ~bus.load & w_tc;
   end

   assign bus.ovf = r_ovf;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.b  = r_b;
   assign bus.g  = r_g;
   assign bus.tc = w_tc;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed checks of the Gray counter (wrap or saturate build, chosen by GRAY_COUNTER_WRAP_EN)
module tb_gray_counter;
`ifdef GRAY_COUNTER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   errs = 0;
   int   checks = 0;

   gray_counter_if #(.WIDTH(3)) bus ();
   gray_counter #(.WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bg(input string tag, input logic [2:0] eb, input logic [2:0] eg, input logic eo);
      chk({tag, ".b"}, 16'(bus.b), 16'(eb));
      chk({tag, ".g"}, 16'(bus.g), 16'(eg));
      chk({tag, ".ovf"}, 16'(bus.ovf), 16'(eo));
   endtask

   task automatic do_load(input logic [2:0] v);
      bus.load = 1'b1; bus.load_b = v; bus.en = 1'b0;
      step();
      bus.load = 1'b0;
   endtask

   logic [2:0] up_b [8];
   logic [2:0] up_g [8];
   logic [2:0] mb, pg;

   initial begin
      rst = 1'b1; bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_b = '0;
      step(); step();
      chk_bg("reset", 3'b000, 3'b000, 1'b0);
      chk("reset.tc_up", 16'(bus.tc), 16'd0);
      bus.up = 1'b0; #1;
      chk("reset.tc_down", 16'(bus.tc), 16'd1);
      // count up through the top
      up_b = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, WRAP ? 3'd0 : 3'd7};
      up_g = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, WRAP ? 3'b000 : 3'b100};
      rst = 1'b0; bus.up = 1'b1; bus.en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("up%0d.tc", i), 16'(bus.tc), 16'(i == 7));
         step();
         chk_bg($sformatf("up%0d", i), up_b[i], up_g[i], WRAP && i == 7);
      end
      bus.en = 1'b0;
      step();
      chk("ovf_one_cycle", 16'(bus.ovf), 16'd0);
      // count down from zero
      do_load(3'b000);
      bus.up = 1'b0; bus.en = 1'b1; #1;
      chk("down.tc", 16'(bus.tc), 16'd1);
      step();
      chk_bg("down0", WRAP ? 3'b111 : 3'b000, WRAP ? 3'b100 : 3'b000, WRAP);
      step();
      chk_bg("down1", WRAP ? 3'b110 : 3'b000, WRAP ? 3'b101 : 3'b000, 1'b0);
      // load beats enable
      bus.load = 1'b1; bus.load_b = 3'b101; bus.en = 1'b1; bus.up = 1'b1;
      step();
      chk_bg("load_en", 3'b101, 3'b111, 1'b0);
      bus.load = 1'b0;
      step();
      chk_bg("after_load", 3'b110, 3'b101, 1'b0);
      // reset beats load and enable
      do_load(3'b011);
      rst = 1'b1; bus.en = 1'b1; bus.load = 1'b1; bus.load_b = 3'b110;
      step();
      chk_bg("rst_mid", 3'b000, 3'b000, 1'b0);
      rst = 1'b0; bus.load = 1'b0;
      // reset at a wrapping edge suppresses the ovf pulse
      do_load(3'b111);
      rst = 1'b1; bus.en = 1'b1; bus.up = 1'b1;
      step();
      chk_bg("rst_wrap", 3'b000, 3'b000, 1'b0);
      rst = 1'b0;
      // enable held at all-ones
      do_load(3'b111);
      bus.en = 1'b1; bus.up = 1'b1;
      step();
      chk_bg("top0", WRAP ? 3'd0 : 3'd7, WRAP ? 3'b000 : 3'b100, WRAP);
      step();
      chk_bg("top1", WRAP ? 3'd1 : 3'd7, WRAP ? 3'b001 : 3'b100, 1'b0);
      step();
      chk_bg("top2", WRAP ? 3'd2 : 3'd7, WRAP ? 3'b011 : 3'b100, 1'b0);
      // direction reversal at a terminal value
      do_load(3'b111);
      bus.up = 1'b1; #1;
      chk("rev.tc_up", 16'(bus.tc), 16'd1);
      bus.up = 1'b0; #1;
      chk("rev.tc_down", 16'(bus.tc), 16'd0);
      bus.en = 1'b1;
      step();
      chk_bg("rev.step", 3'b110, 3'b101, 1'b0);
      // random enable/direction against a reference count
      mb = bus.b;
      for (int i = 0; i < 200; i++) begin
         bus.en = 1'($urandom_range(0, 1));
         bus.up = 1'($urandom_range(0, 1));
         pg = bus.g;
         if (bus.en) begin
            if (bus.up) mb = (mb == 3'd7) ? (WRAP ? 3'd0 : 3'd7) : mb + 3'd1;
            else        mb = (mb == 3'd0) ? (WRAP ? 3'd7 : 3'd0) : mb - 3'd1;
         end
         step();
         chk($sformatf("rnd%0d.b", i), 16'(bus.b), 16'(mb));
         chk($sformatf("rnd%0d.g", i), 16'(bus.g), 16'(mb ^ (mb >> 1)));
         if (bus.g !== pg) chk($sformatf("rnd%0d.onebit", i), 16'($countones(bus.g ^ pg)), 16'd1);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
